ripple_carry_counter: RTL and testbench

RIPPLE_CARRY_COUNTER -- requirements
Module: ripple_carry_counter

---
 rtl/ripple_carry_counter_pkg.sv | 9 +
 rtl/t_ff.sv | 22 ++
 rtl/ripple_carry_counter.sv | 41 ++++
 tb/tb_ripple_carry_counter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ripple_carry_counter_pkg.sv
// Shared constants for the ripple carry counter: default stage count and reset value.
// Optional terminal-count output is enabled by defining RIPPLE_CARRY_COUNTER_TC_EN.
package ripple_carry_counter_pkg;

    localparam int          DEFAULT_WIDTH = 4;
    localparam int          MAX_WIDTH     = 32;
    localparam logic [MAX_WIDTH-1:0] RESET_VALUE = '0;

endpackage

// File: rtl/t_ff.sv
// Falling-edge toggle flip-flop with asynchronous active-low clear.
// One stage of the ripple counter; its output also clocks the next stage.
module t_ff
    import ripple_carry_counter_pkg::*;
#(
    parameter logic RESET_BIT = RESET_VALUE[0]
) (
    input  logic clk,
    input  logic rst_n,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignments so chained stages see the pre-edge value.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_BIT;
        end else begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/ripple_carry_counter.sv
// Asynchronous ripple up-counter: stage 0 runs off clk, each later stage off the previous q bit.
// Define RIPPLE_CARRY_COUNTER_TC_EN to add the combinational terminal-count output tc.
module ripple_carry_counter
    import ripple_carry_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
    ,
    output logic             tc
`endif
);

    logic [WIDTH-1:0] stage_clk;

    // Reset goes to every stage directly so a clear never waits on the ripple.
    for (genvar g = 0; g < WIDTH; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign stage_clk[g] = clk;
        end else begin : g_chain
            assign stage_clk[g] = q[g-1];
        end

        t_ff #(
            .RESET_BIT (RESET_VALUE[g])
        ) u_t_ff (
            .clk   (stage_clk[g]),
            .rst_n (reset),
            .q     (q[g])
        );
    end

`ifdef RIPPLE_CARRY_COUNTER_TC_EN
    // q is forced to zero during reset, so tc drops with it.
    assign tc = &q;
`endif

endmodule

// File: tb/tb_ripple_carry_counter.sv
// Directed self-checking bench for ripple_carry_counter (4-bit and 8-bit instances).
// Checks tc as well when RIPPLE_CARRY_COUNTER_TC_EN is defined.
module tb_ripple_carry_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       reset8 = 1'b0;
    logic [3:0] q;
    logic [7:0] q8;
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
    logic       tc;
    logic       tc8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ripple_carry_counter #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
        ,
        .tc    (tc)
`endif
    );

    ripple_carry_counter #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset8),
        .q     (q8)
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
        ,
        .tc    (tc8)
`endif
    );

    // Low 0-50, high 50-100: falling edges at 100, 200, ...
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_until(input longint t);
        if ($time < t) #(t - $time);
    endtask

    initial begin
        // Reset held with clk running.
        wait_until(5);
        check("rst_q_5", q, 0);
        wait_until(14);
        check("rst_q_14", q, 0);
        check("rst_q8_14", q8, 0);
        reset  = 1'b1;
        reset8 = 1'b1;
        wait_until(15);
        check("rst_q_15", q, 0);

        // Counting; rising edges must not disturb q.
        wait_until(51);
        check("rise_50", q, 0);
        wait_until(101);
        check("cnt_100", q, 1);
        wait_until(151);
        check("rise_150", q, 1);
        wait_until(201);
        check("cnt_200", q, 2);
        wait_until(251);
        check("rise_250", q, 2);
        wait_until(501);
        check("cnt_500", q, 5);
        check("cnt8_500", q8, 5);
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
        check("tc_500", tc, 0);
`endif

        // Mid-count reset pulse straddling a falling edge.
        wait_until(595);
        reset = 1'b0;
        #1;
        check("midrst_async", q, 0);
        wait_until(601);
        check("midrst_hold", q, 0);
        wait_until(605);
        reset = 1'b1;
        wait_until(701);
        check("midrst_restart", q, 1);
        check("cnt8_700", q8, 7);

        // Wrap-around: fresh reset, then 16 falling edges.
        wait_until(795);
        reset = 1'b0;
        wait_until(805);
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wait_until(800 + i * 100 + 1);
            check($sformatf("wrap_%0d", i), q, i % 16);
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
            check($sformatf("tc_%0d", i), tc, (i == 15) ? 1 : 0);
`endif
        end

        // 8-bit instance: released at 15 ns, so edge n lands at n*100.
        wait_until(12701);
        check("w8_127", q8, 127);
        wait_until(12801);
        check("w8_128", q8, 128);
        wait_until(25501);
        check("w8_255", q8, 255);
`ifdef RIPPLE_CARRY_COUNTER_TC_EN
        check("tc8_255", tc8, 1);
`endif
        wait_until(25601);
        check("w8_256", q8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
